// File: rtl/mem_ctrl_pkg.sv
// Shared types for the memory access controller.
//   size_e  : access size encoding as presented on req_size
//   state_e : controller FSM states
//   access_fault() : flags misaligned or illegal-size accesses
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

  function automatic logic access_fault(input size_e size, input logic [1:0] byte_off);
    logic fault;
    case (size)
      SIZE_BYTE: fault = 1'b0;
      SIZE_HALF: fault = byte_off[0];
      SIZE_WORD: fault = |byte_off;
      default:   fault = 1'b1;
    endcase
    return fault;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for the memory access controller.
// Ports:
//   word        : word currently read from memory
//   byte_off    : byte offset of the access within the word
//   size        : access size (size_e encoding)
//   is_unsigned : zero-extend loads when 1, sign-extend when 0
//   store_data  : right-aligned store data
//   load_data   : addressed lane extracted and extended
//   merged      : word with the store lanes replaced, other bytes kept
module mem_lane_align
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [1:0]            byte_off,
  input  logic [1:0]            size,
  input  logic                  is_unsigned,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] merged
);

  logic [4:0]            lane_shift;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] lane_mask;

  assign lane_shift = {byte_off, 3'b000};
  assign shifted    = word >> lane_shift;

  always_comb begin
    load_data = word;
    lane_mask = '1;
    case (size)
      SIZE_BYTE: begin
        load_data = {{(DATA_WIDTH-8){~is_unsigned & shifted[7]}}, shifted[7:0]};
        lane_mask = DATA_WIDTH'(8'hFF) << lane_shift;
      end
      SIZE_HALF: begin
        load_data = {{(DATA_WIDTH-16){~is_unsigned & shifted[15]}}, shifted[15:0]};
        lane_mask = DATA_WIDTH'(16'hFFFF) << lane_shift;
      end
      default: begin
        load_data = word;
        lane_mask = '1;
      end
    endcase
  end

  // Store data is right-aligned, so it is shifted up into the addressed lane
  // and the mask drops any bits above the access size.
  assign merged = (word & ~lane_mask) | ((store_data << lane_shift) & lane_mask);

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller in front of a word memory with combinational read
// and synchronous write. Sub-word stores are done as read-modify-write.
// Ports:
//   clk, rst_n                    : clock, async active-low reset
//   req_valid/req_ready           : request handshake (ready only in IDLE)
//   req_write/size/unsigned/addr/wdata : access description (byte address)
//   resp_valid/rdata/error        : one-cycle completion pulse and result
//   mem_address/write_data/write_enable/read_data : word memory port
//
// state    | meaning
// ST_IDLE  | waiting for a request; req_ready high
// ST_READ  | word read: load extract, or sub-word store merge
// ST_WRITE | single-cycle memory write
// ST_RESP  | resp_valid pulse, then back to IDLE
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 30
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [ADDRESS_WIDTH+1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_error,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_write_data,
  output logic                     mem_write_enable,
  input  logic [DATA_WIDTH-1:0]    mem_read_data
);

  state_e                   state, state_next;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [1:0]               off_q;
  size_e                    size_q;
  logic                     write_q;
  logic                     uns_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [DATA_WIDTH-1:0]    merged_q;
  logic [DATA_WIDTH-1:0]    rdata_q;
  logic                     err_q;

  logic                     accept;
  logic                     fault;
  logic [DATA_WIDTH-1:0]    load_data;
  logic [DATA_WIDTH-1:0]    merged;

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign fault     = access_fault(size_e'(req_size), req_addr[1:0]);

  mem_lane_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane_align (
    .word        (mem_read_data),
    .byte_off    (off_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .store_data  (wdata_q),
    .load_data   (load_data),
    .merged      (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (fault)
            state_next = ST_RESP;
          else if (req_write && (size_e'(req_size) == SIZE_WORD))
            state_next = ST_WRITE;
          else
            state_next = ST_READ;
        end
      end
      ST_READ:  state_next = write_q ? ST_WRITE : ST_RESP;
      ST_WRITE: state_next = ST_RESP;
      ST_RESP:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      off_q    <= '0;
      size_q   <= SIZE_BYTE;
      write_q  <= 1'b0;
      uns_q    <= 1'b0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      addr_q   <= req_addr[ADDRESS_WIDTH+1:2];
      off_q    <= req_addr[1:0];
      size_q   <= size_e'(req_size);
      write_q  <= req_write;
      uns_q    <= req_unsigned;
      wdata_q  <= req_wdata;
      rdata_q  <= '0;
      err_q    <= fault;
    end else if (state == ST_READ) begin
      if (write_q)
        merged_q <= merged;
      else
        rdata_q  <= load_data;
    end
  end

  assign mem_address      = addr_q;
  assign mem_write_enable = (state == ST_WRITE);
  assign mem_write_data   = (state != ST_WRITE) ? '0 :
                            (size_q == SIZE_WORD) ? wdata_q : merged_q;
  assign resp_valid       = (state == ST_RESP);
  assign resp_error       = (state == ST_RESP) && err_q;
  assign resp_rdata       = (state == ST_RESP) ? rdata_q : '0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [29:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:255];

  int vectors;
  int miscompares;

  int          nr, nw, wc;
  logic [31:0] rd, wdt;
  logic        er;
  logic [29:0] wa, a1;

  mem_access_ctrl #(
    .DATA_WIDTH    (32),
    .ADDRESS_WIDTH (30)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_size         (req_size),
    .req_unsigned     (req_unsigned),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_error       (resp_error),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_data    (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_address[7:0]];
  always @(posedge clk) if (mem_write_enable) mem[mem_address[7:0]] <= mem_write_data;

  // Presents one access, scrambles the request inputs after acceptance, and
  // watches up to 8 cycles. Cycle 1 is the cycle right after the accepting edge.
  task automatic run_access(input logic wr, input logic [1:0] sz, input logic un,
                            input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = un;
    req_addr = addr; req_wdata = wd;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++; $display("FAIL accept_ready: got %b want 1", req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0; req_write = ~wr; req_size = ~sz; req_unsigned = ~un;
    req_addr = ~addr; req_wdata = ~wd;
    nr = 0; nw = 0; wc = 0; rd = 'x; er = 1'bx; wa = '0; wdt = '0; a1 = '0;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 1) a1 = mem_address;
      if (mem_write_enable) begin nw++; wc = c; wa = mem_address; wdt = mem_write_data; end
      if (resp_valid) begin nr = c; rd = resp_rdata; er = resp_error; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    vectors++; if (mem_write_enable !== 1'b0) begin miscompares++; $display("FAIL rst_we: got %b want 0", mem_write_enable); end
    vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    vectors++; if (resp_error !== 1'b0) begin miscompares++; $display("FAIL rst_resp_error: got %b want 0", resp_error); end
    vectors++; if (resp_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rdata: got %h want 0", resp_rdata); end
    vectors++; if (mem_address !== 30'h0) begin miscompares++; $display("FAIL rst_addr: got %h want 0", mem_address); end
    vectors++; if (mem_write_data !== 32'h0) begin miscompares++; $display("FAIL rst_wdata: got %h want 0", mem_write_data); end
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [1:0]  sz;
    logic        un;
    logic [31:0] addr;
    logic [31:0] exp;
  } ld_t;

  task automatic test_load();
    ld_t tbl [11];
    mem[8'h10] = 32'h8899_AABB;
    mem[8'h11] = 32'h7F00_0012;
    tbl = '{
      '{2'b00, 1'b0, 32'h42, 32'hFFFF_FF99},
      '{2'b00, 1'b1, 32'h42, 32'h0000_0099},
      '{2'b00, 1'b0, 32'h40, 32'hFFFF_FFBB},
      '{2'b00, 1'b0, 32'h41, 32'hFFFF_FFAA},
      '{2'b00, 1'b0, 32'h43, 32'hFFFF_FF88},
      '{2'b01, 1'b0, 32'h42, 32'hFFFF_8899},
      '{2'b01, 1'b1, 32'h42, 32'h0000_8899},
      '{2'b01, 1'b0, 32'h40, 32'hFFFF_AABB},
      '{2'b10, 1'b0, 32'h40, 32'h8899_AABB},
      '{2'b00, 1'b0, 32'h47, 32'h0000_007F},
      '{2'b01, 1'b0, 32'h44, 32'h0000_0012}
    };
    foreach (tbl[i]) begin
      run_access(1'b0, tbl[i].sz, tbl[i].un, tbl[i].addr, 32'h5555_5555);
      vectors++; if (nr !== 2) begin miscompares++; $display("FAIL load%0d_latency: got %0d want 2", i, nr); end
      vectors++; if (rd !== tbl[i].exp) begin miscompares++; $display("FAIL load%0d_rdata: got %h want %h", i, rd, tbl[i].exp); end
      vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL load%0d_error: got %b want 0", i, er); end
      vectors++; if (nw !== 0) begin miscompares++; $display("FAIL load%0d_writes: got %0d want 0", i, nw); end
      vectors++; if (a1 !== tbl[i].addr[31:2]) begin miscompares++; $display("FAIL load%0d_addr: got %h want %h", i, a1, tbl[i].addr[31:2]); end
    end
  endtask

  typedef struct {
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp;
  } st_t;

  task automatic test_subword_store();
    st_t tbl [3];
    mem[8'h10] = 32'h1122_3344;
    tbl = '{
      '{2'b01, 32'h42, 32'h0000_BEEF, 32'hBEEF_3344},
      '{2'b00, 32'h41, 32'hFFFF_FF5A, 32'hBEEF_5A44},
      '{2'b01, 32'h40, 32'h1234_5678, 32'hBEEF_5678}
    };
    foreach (tbl[i]) begin
      run_access(1'b1, tbl[i].sz, 1'b0, tbl[i].addr, tbl[i].wd);
      vectors++; if (nr !== 3) begin miscompares++; $display("FAIL sst%0d_latency: got %0d want 3", i, nr); end
      vectors++; if (nw !== 1 || wc !== 2) begin miscompares++; $display("FAIL sst%0d_write_cycle: got %0d writes at %0d want 1 at 2", i, nw, wc); end
      vectors++; if (wa !== 30'h10) begin miscompares++; $display("FAIL sst%0d_waddr: got %h want 10", i, wa); end
      vectors++; if (wdt !== tbl[i].exp) begin miscompares++; $display("FAIL sst%0d_wdata: got %h want %h", i, wdt, tbl[i].exp); end
      vectors++; if (rd !== 32'h0 || er !== 1'b0) begin miscompares++; $display("FAIL sst%0d_resp: got %h/%b want 0/0", i, rd, er); end
      vectors++; if (mem[8'h10] !== tbl[i].exp) begin miscompares++; $display("FAIL sst%0d_mem: got %h want %h", i, mem[8'h10], tbl[i].exp); end
    end
  endtask

  task automatic test_word_store();
    mem[8'h40] = 32'h0;
    run_access(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF);
    vectors++; if (nr !== 2) begin miscompares++; $display("FAIL sw_latency: got %0d want 2", nr); end
    vectors++; if (nw !== 1 || wc !== 1) begin miscompares++; $display("FAIL sw_write_cycle: got %0d writes at %0d want 1 at 1", nw, wc); end
    vectors++; if (wa !== 30'h40) begin miscompares++; $display("FAIL sw_waddr: got %h want 40", wa); end
    vectors++; if (wdt !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL sw_wdata: got %h want deadbeef", wdt); end
    vectors++; if (mem[8'h40] !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL sw_mem: got %h want deadbeef", mem[8'h40]); end
    vectors++; if (rd !== 32'h0 || er !== 1'b0) begin miscompares++; $display("FAIL sw_resp: got %h/%b want 0/0", rd, er); end
  endtask

  task automatic test_misaligned();
    logic        wr_t [6];
    logic [1:0]  sz_t [6];
    logic [31:0] ad_t [6];
    logic [31:0] snap;
    wr_t = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    sz_t = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b11, 2'b11};
    ad_t = '{32'h102, 32'h43, 32'h41, 32'h45, 32'h40, 32'h100};
    mem[8'h10] = 32'hCAFE_1234;
    for (int i = 0; i < 6; i++) begin
      snap = mem[ad_t[i][9:2]];
      run_access(wr_t[i], sz_t[i], 1'b0, ad_t[i], 32'h7777_7777);
      vectors++; if (nr !== 1) begin miscompares++; $display("FAIL mis%0d_latency: got %0d want 1", i, nr); end
      vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL mis%0d_error: got %b want 1", i, er); end
      vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL mis%0d_rdata: got %h want 0", i, rd); end
      // Let any stray write land before checking memory.
      @(negedge clk);
      if (mem_write_enable) nw++;
      vectors++; if (nw !== 0) begin miscompares++; $display("FAIL mis%0d_writes: got %0d want 0", i, nw); end
      vectors++; if (mem[ad_t[i][9:2]] !== snap) begin miscompares++; $display("FAIL mis%0d_mem: got %h want %h", i, mem[ad_t[i][9:2]], snap); end
    end
  endtask

  task automatic test_reset_mid_write();
    logic seen;
    mem[8'h20] = 32'h1234_5678;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h80; req_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    req_valid = 1'b0;
    vectors++; if (mem_write_enable !== 1'b1) begin miscompares++; $display("FAIL rmid_in_write: got %b want 1", mem_write_enable); end
    #1 rst_n = 1'b0;
    #1;
    vectors++; if (mem_write_enable !== 1'b0) begin miscompares++; $display("FAIL rmid_we_drop: got %b want 0", mem_write_enable); end
    vectors++; if (mem_write_data !== 32'h0) begin miscompares++; $display("FAIL rmid_wdata: got %h want 0", mem_write_data); end
    vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_resp: got %b want 0", resp_valid); end
    repeat (2) @(negedge clk);
    vectors++; if (mem[8'h20] !== 32'h1234_5678) begin miscompares++; $display("FAIL rmid_mem: got %h want 12345678", mem[8'h20]); end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_ready: got %b want 1", req_ready); end
    seen = resp_valid | mem_write_enable;
    repeat (4) begin
      @(negedge clk);
      seen |= resp_valid | mem_write_enable;
    end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL rmid_no_activity: got %b want 0", seen); end
    vectors++; if (mem[8'h20] !== 32'h1234_5678) begin miscompares++; $display("FAIL rmid_mem_after: got %h want 12345678", mem[8'h20]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] baddr [3];
    logic [31:0] bexp  [3];
    int acc [3];
    int na, nresp;
    logic pend;
    baddr = '{32'h40, 32'h44, 32'h48};
    bexp  = '{32'h8899_AABB, 32'h0102_0304, 32'hA5A5_A5A5};
    acc   = '{0, 0, 0};
    mem[8'h10] = 32'h8899_AABB;
    mem[8'h11] = 32'h0102_0304;
    mem[8'h12] = 32'hA5A5_A5A5;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = baddr[0];
    na = 0; nresp = 0; pend = 1'b0;
    for (int i = 0; i < 20 && nresp < 3; i++) begin
      if (i > 0) @(negedge clk);
      if (resp_valid) begin
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_resp: got %b want 0", req_ready); end
        vectors++; if (resp_rdata !== bexp[nresp]) begin miscompares++; $display("FAIL b2b_rdata%0d: got %h want %h", nresp, resp_rdata, bexp[nresp]); end
        nresp++;
      end
      if (pend) begin
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_read: got %b want 0", req_ready); end
        if (na < 3) req_addr = baddr[na];
        else        req_valid = 1'b0;
        pend = 1'b0;
      end
      if (req_ready && req_valid && na < 3) begin
        acc[na] = i; na++; pend = 1'b1;
      end
    end
    req_valid = 1'b0;
    vectors++; if (na !== 3 || nresp !== 3) begin miscompares++; $display("FAIL b2b_count: got %0d acc %0d resp want 3 3", na, nresp); end
    vectors++; if (acc[1] - acc[0] !== 3) begin miscompares++; $display("FAIL b2b_gap01: got %0d want 3", acc[1] - acc[0]); end
    vectors++; if (acc[2] - acc[1] !== 3) begin miscompares++; $display("FAIL b2b_gap12: got %0d want 3", acc[2] - acc[1]); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    test_reset();
    test_load();
    test_subword_store();
    test_word_store();
    test_misaligned();
    test_reset_mid_write();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, memory word width in bits.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 30, word-address width driven to data memory.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid  input  1  requester presents an access.
REQ-006 SHALL have port req_ready  output  1  controller accepts an access this cycle.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 SHALL have port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 SHALL have port req_addr  input  ADDRESS_WIDTH+2  byte address.
REQ-011 SHALL have port req_wdata  input  DATA_WIDTH  store data, right-aligned.
REQ-012 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-013 SHALL have port resp_rdata  output  DATA_WIDTH  extended load data; 0 for stores and errors.
REQ-014 SHALL have port resp_error  output  1  misaligned or illegal-size access, qualified by resp_valid.
REQ-015 SHALL have ports mem_address (output, ADDRESS_WIDTH), mem_write_data (output, DATA_WIDTH), mem_write_enable (output, 1) and mem_read_data (input, DATA_WIDTH), connecting to a word memory with combinational read and a synchronous write.

Function
REQ-016 SHALL implement a four-state FSM: IDLE, READ, WRITE, RESP.
REQ-017 SHALL drive req_ready = 1 only in IDLE; an access is accepted on a rising edge with req_valid && req_ready.
REQ-018 SHALL register req_addr[ADDRESS_WIDTH+1:2], the byte offset, size, write, unsigned and wdata at acceptance; mem_address SHALL be driven from the registered word address.
REQ-019 SHALL check alignment at acceptance: half with addr[0]=1, word with addr[1:0]!=0, or size=11 -> next state RESP with resp_error=1, resp_rdata=0, and no memory write.
REQ-020 SHALL route an aligned load IDLE->READ->RESP: in READ, capture mem_read_data, select the addressed byte/half/word lane, and extend per req_unsigned into the response register; resp_valid SHALL pulse 2 cycles after acceptance.
REQ-021 SHALL route an aligned word store IDLE->WRITE->RESP, so resp_valid pulses 2 cycles after acceptance.
REQ-022 SHALL route an aligned byte/half store IDLE->READ->WRITE->RESP: in READ, merge the store lanes into the captured word, leaving other bytes unchanged; resp_valid SHALL pulse 3 cycles after acceptance.
REQ-023 SHALL assert mem_write_enable for exactly one cycle, only in WRITE, with mem_write_data = the merged word (sub-word) or the registered wdata (word).
REQ-024 SHALL hold resp_valid high for exactly one cycle in RESP, then return to IDLE; there is no response backpressure.
REQ-025 SHALL return to IDLE from RESP even if req_valid is high, so back-to-back accesses occur at most one every 3 cycles.
REQ-026 SHALL ignore req_* inputs outside IDLE; changes mid-access SHALL NOT affect the access in flight.
REQ-027 SHALL drive mem_write_data = 0 when not in WRITE.

Reset
REQ-028 SHALL, while rst_n=0, force state IDLE and clear all registers, so mem_write_enable=0, resp_valid=0, resp_error=0, resp_rdata=0, mem_address=0 and req_ready=1.
REQ-029 SHALL abort an access in flight when reset asserts; no write is issued and no response is produced, including when reset asserts during WRITE (mem_write_enable drops asynchronously).

Structure
REQ-030 SHALL place the size encoding enum and the FSM state enum in shared package mem_ctrl_pkg.
REQ-031 SHALL contain one combinational sub-module, mem_lane_align, which performs lane extract/extend for loads and lane merge for stores.

Verification
REQ-032 Load: word 0x0000_0010 holds 0x8899_AABB; LB at 0x42, signed -> resp_rdata 0xFFFF_FF99 two cycles after acceptance; LBU -> 0x0000_0099.
REQ-033 Sub-word store: word 0x10 holds 0x1122_3344; SH of 0xBEEF at 0x42 -> one write of 0xBEEF_3344 to word 0x10 in cycle 2, resp_valid in cycle 3.
REQ-034 Word store: SW of 0xDEAD_BEEF at 0x100 -> mem_write_enable high for one cycle with mem_address 0x40 and data 0xDEAD_BEEF; resp_valid 2 cycles after acceptance.
REQ-035 Misaligned: SW at 0x102 -> resp_error=1, resp_rdata=0 one cycle after acceptance, and mem_write_enable never asserts.
REQ-036 Reset mid-operation: assert rst_n=0 while in WRITE -> mem_write_enable low immediately, memory unchanged, no resp_valid, and req_ready=1 after release.
REQ-037 Back-to-back: req_valid held high with three loads -> acceptances spaced exactly 3 cycles apart, and req_ready=0 in READ and RESP.
